ticket_vend_ctrl: RTL

Parametrised ticket-vending controller for the station fare machine: accepts a trip request (origin, destination, ticket count), quotes a distance-based fare, accumulates coins, and then either issues tickets with change or refunds on cancel or inactivity timeout. It sits between the front-panel/coin-acceptor logic and the ticket/change dispenser. It generalises the single-trip vending FSM to configurable station count, money width, and ticket limit, and adds valid/ready handshakes, input validation, cancel, timeout refund and coin-overflow rejection.

---
 rtl/ticket_vend_ctrl_pkg.sv | 37 +++
 rtl/ticket_vend_ctrl_timeout.sv | 41 ++++
 rtl/ticket_vend_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ticket_vend_ctrl_pkg.sv
// Shared definitions for the ticket vending controller.
//   vend_state_e : controller state encoding
//   fare_calc    : per-ticket fare, (|orig-dest|+1)*unit
//   params_ok    : parameter sanity check used at elaboration of the top
package vend_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_QUOTE,
      ST_PAY,
      ST_DISPENSE,
      ST_REFUND
   } vend_state_e;

   function automatic int unsigned fare_calc(input int unsigned orig,
                                             input int unsigned dest,
                                             input int unsigned unit);
      int unsigned span;
      span = (orig > dest) ? (orig - dest) : (dest - orig);
      return (span + 1) * unit;
   endfunction

   // Largest possible amount_due must fit in MONEY_W bits and the ticket
   // limit must be representable in CNT_W bits.
   function automatic bit params_ok(input int unsigned n_stations,
                                    input int unsigned fare_unit,
                                    input int unsigned max_tickets,
                                    input int unsigned money_w,
                                    input int unsigned cnt_w);
      longint unsigned money_max;
      longint unsigned worst;
      money_max = (64'd1 << money_w) - 64'd1;
      worst     = longint'(fare_unit) * longint'(n_stations) * longint'(max_tickets);
      return (worst <= money_max) && (longint'(max_tickets) < (64'd1 << cnt_w));
   endfunction

endpackage

// File: rtl/ticket_vend_ctrl_timeout.sv
// Idle counter for the PAY state.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : restart the count from zero (wins over enable)
//   enable     : advance the count by one
//   expire     : count has reached TIMEOUT_CYC-1; always 0 when TIMEOUT_CYC=0
module vend_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
   localparam int unsigned CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // Count saturates at LAST; with TIMEOUT_CYC=0 it stays at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != CW'(LAST))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (TIMEOUT_CYC != 0) && (cnt_q == CW'(LAST));

endmodule

// File: rtl/ticket_vend_ctrl.sv
// Ticket vending controller: validates a trip request, quotes a
// distance-based fare, accumulates coins, then issues tickets with change
// or refunds on cancel / inactivity timeout.
//   clk, reset              : clock, asynchronous active-low reset
//   req_valid/req_ready     : trip request handshake (origin, destination,
//                             ticket_count)
//   coin_valid/coin_ready   : coin handshake (coin_value); coin_reject pulses
//                             for any coin offered but not accepted
//   cancel                  : user cancel, honoured only while paying
//   err_invalid             : pulse for a rejected request
//   unit_fare, amount_due,
//   credit                  : current transaction money values
//   done_valid/done_ready   : result handshake (done_tickets, done_change)
module ticket_vend_ctrl
   import vend_pkg::*;
#(
   parameter int unsigned N_STATIONS  = 8,
   parameter int unsigned STN_W       = $clog2(N_STATIONS),
   parameter int unsigned FARE_UNIT   = 5,
   parameter int unsigned MAX_TICKETS = 15,
   parameter int unsigned CNT_W       = 4,
   parameter int unsigned MONEY_W     = 16,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [STN_W-1:0]   origin,
   input  logic [STN_W-1:0]   destination,
   input  logic [CNT_W-1:0]   ticket_count,
   input  logic               coin_valid,
   input  logic [MONEY_W-1:0] coin_value,
   output logic               coin_ready,
   output logic               coin_reject,
   input  logic               cancel,
   output logic               err_invalid,
   output logic [MONEY_W-1:0] unit_fare,
   output logic [MONEY_W-1:0] amount_due,
   output logic [MONEY_W-1:0] credit,
   output logic               done_valid,
   input  logic               done_ready,
   output logic [CNT_W-1:0]   done_tickets,
   output logic [MONEY_W-1:0] done_change
);

   if (!params_ok(N_STATIONS, FARE_UNIT, MAX_TICKETS, MONEY_W, CNT_W)) begin : g_param_err
      $error("ticket_vend_ctrl: fare range exceeds MONEY_W or MAX_TICKETS exceeds CNT_W");
   end

   vend_state_e        state_q, state_d;
   logic [STN_W-1:0]   orig_q, orig_d, dest_q, dest_d;
   logic [CNT_W-1:0]   tkt_q, tkt_d;
   logic [MONEY_W-1:0] unit_fare_q, unit_fare_d;
   logic [MONEY_W-1:0] amount_due_q, amount_due_d;
   logic [MONEY_W-1:0] credit_q, credit_d;
   logic [MONEY_W-1:0] done_change_q, done_change_d;
   logic [CNT_W-1:0]   done_tickets_q, done_tickets_d;
   logic               req_ready_q, req_ready_d;
   logic               coin_ready_q, coin_ready_d;
   logic               coin_reject_q, coin_reject_d;
   logic               err_invalid_q, err_invalid_d;
   logic               done_valid_q, done_valid_d;

   logic [MONEY_W:0]   coin_sum;
   logic               coin_ovf;
   logic               coin_acc;
   logic [MONEY_W-1:0] new_credit;
   logic               paid;
   logic               req_ok;
   logic               tmo_clear;
   logic               tmo_en;
   logic               tmo_expire;

   // One extra bit on the sum exposes a coin that would wrap the credit.
   always_comb begin
      coin_sum   = {1'b0, credit_q} + {1'b0, coin_value};
      coin_ovf   = coin_sum[MONEY_W];
      coin_acc   = (state_q == ST_PAY) && coin_valid && !coin_ovf;
      new_credit = coin_acc ? coin_sum[MONEY_W-1:0] : credit_q;
      paid       = (new_credit >= amount_due_q);
      req_ok     = (32'(origin) < N_STATIONS) && (32'(destination) < N_STATIONS) &&
                   (origin != destination) && (ticket_count != '0) &&
                   (32'(ticket_count) <= MAX_TICKETS);
      tmo_clear  = (state_q == ST_QUOTE) || coin_acc;
      tmo_en     = (state_q == ST_PAY);
   end

   vend_timeout_ctr #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_tmo (
      .clk    (clk),
      .reset  (reset),
      .clear  (tmo_clear),
      .enable (tmo_en),
      .expire (tmo_expire)
   );

   always_comb begin
      state_d        = state_q;
      orig_d         = orig_q;
      dest_d         = dest_q;
      tkt_d          = tkt_q;
      unit_fare_d    = unit_fare_q;
      amount_due_d   = amount_due_q;
      credit_d       = credit_q;
      done_valid_d   = done_valid_q;
      done_tickets_d = done_tickets_q;
      done_change_d  = done_change_q;
      err_invalid_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_ok) begin
                  orig_d  = origin;
                  dest_d  = destination;
                  tkt_d   = ticket_count;
                  state_d = ST_QUOTE;
               end else begin
                  err_invalid_d = 1'b1;
               end
            end
         end
         ST_QUOTE: begin
            unit_fare_d  = MONEY_W'(fare_calc(32'(orig_q), 32'(dest_q), FARE_UNIT));
            amount_due_d = MONEY_W'(fare_calc(32'(orig_q), 32'(dest_q), FARE_UNIT) * 32'(tkt_q));
            credit_d     = '0;
            state_d      = ST_PAY;
         end
         ST_PAY: begin
            credit_d = new_credit;
            // A coin in the same cycle as cancel/expiry is counted first;
            // an accepted coin also restarts the idle count, so it beats expiry.
            if (paid) begin
               state_d        = ST_DISPENSE;
               done_valid_d   = 1'b1;
               done_tickets_d = tkt_q;
               done_change_d  = new_credit - amount_due_q;
            end else if (cancel || (tmo_expire && !coin_acc)) begin
               state_d        = ST_REFUND;
               done_valid_d   = 1'b1;
               done_tickets_d = '0;
               done_change_d  = new_credit;
            end
         end
         ST_DISPENSE, ST_REFUND: begin
            if (done_ready) begin
               state_d        = ST_IDLE;
               unit_fare_d    = '0;
               amount_due_d   = '0;
               credit_d       = '0;
               done_valid_d   = 1'b0;
               done_tickets_d = '0;
               done_change_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      coin_reject_d = coin_valid && !coin_acc;
      req_ready_d   = (state_d == ST_IDLE);
      coin_ready_d  = (state_d == ST_PAY);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         orig_q         <= '0;
         dest_q         <= '0;
         tkt_q          <= '0;
         unit_fare_q    <= '0;
         amount_due_q   <= '0;
         credit_q       <= '0;
         done_valid_q   <= 1'b0;
         done_tickets_q <= '0;
         done_change_q  <= '0;
         err_invalid_q  <= 1'b0;
         coin_reject_q  <= 1'b0;
         req_ready_q    <= 1'b1;
         coin_ready_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         orig_q         <= orig_d;
         dest_q         <= dest_d;
         tkt_q          <= tkt_d;
         unit_fare_q    <= unit_fare_d;
         amount_due_q   <= amount_due_d;
         credit_q       <= credit_d;
         done_valid_q   <= done_valid_d;
         done_tickets_q <= done_tickets_d;
         done_change_q  <= done_change_d;
         err_invalid_q  <= err_invalid_d;
         coin_reject_q  <= coin_reject_d;
         req_ready_q    <= req_ready_d;
         coin_ready_q   <= coin_ready_d;
      end
   end

   assign req_ready    = req_ready_q;
   assign coin_ready   = coin_ready_q;
   assign coin_reject  = coin_reject_q;
   assign err_invalid  = err_invalid_q;
   assign unit_fare    = unit_fare_q;
   assign amount_due   = amount_due_q;
   assign credit       = credit_q;
   assign done_valid   = done_valid_q;
   assign done_tickets = done_tickets_q;
   assign done_change  = done_change_q;

endmodule
